// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
// Baud-derived values assume a 50 MHz system clock and 115200 baud.
package uart_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned BIT_TIME     = CLK_HZ / BAUD;   // clk cycles per UART bit
    localparam int unsigned BAUD_CNT_MAX = BIT_TIME - 1;

    // Ten bit times is one full 8N1 character.
    localparam logic [31:0] IDLE_TIMEOUT_DEF = 32'(10 * BIT_TIME);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around; returns one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    always_comb begin : pick
        int              j;
        logic [ID_W-1:0] cand;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            cand = ID_W'(j);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX among NUM_REQ byte
// streams, with an idle watchdog that releases a requester stalled mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int          ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 abort_o,
    output logic [ID_W-1:0]      abort_id_o
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [31:0]        wd_cnt_q, wd_cnt_d;
    logic               abort_q, abort_d;
    logic [ID_W-1:0]    abort_id_q, abort_id_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    logic               busy;
    logic               owner_valid;
    logic               xfer;
    logic [ID_W-1:0]    ptr_next;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign busy        = (state_q == BUSY);
    assign owner_valid = req_valid_i[owner_q];
    assign xfer        = busy && owner_valid && tx_ready_i;
    assign ptr_next    = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Datapath: the owner's stream is passed straight through while busy.
    always_comb begin
        tx_data_o   = '0;
        req_ready_o = '0;
        if (busy) begin
            req_ready_o[owner_q] = tx_ready_i;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner_q == ID_W'(k)) tx_data_o = req_data_i[8*k +: 8];
            end
        end
    end

    assign tx_valid_o = busy && owner_valid;
    assign grant_o    = grant_q;
    assign busy_o     = busy;
    assign abort_o    = abort_q;
    assign abort_id_o = abort_id_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wd_cnt_d   = wd_cnt_q;
        abort_d    = 1'b0;
        abort_id_d = abort_id_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = BUSY;
                    grant_d  = pick_grant;
                    owner_d  = pick_idx;
                    wd_cnt_d = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    wd_cnt_d = '0;
                    if (req_last_i[owner_q]) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end
                end else if (!owner_valid) begin
                    // Only a silent owner feeds the watchdog; a downstream stall holds it.
                    if (wd_cnt_q == IDLE_TIMEOUT - 32'd1) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        ptr_d      = ptr_next;
                        wd_cnt_d   = '0;
                        abort_d    = 1'b1;
                        abort_id_d = owner_q;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            wd_cnt_q   <= '0;
            abort_q    <= 1'b0;
            abort_id_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wd_cnt_q   <= wd_cnt_d;
            abort_q    <= abort_d;
            abort_id_q <= abort_id_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for basic arbitration,
// then hand-written sequences for contention, stalls, watchdog, reset and wrap.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int          N  = 4;
    localparam logic [31:0] IT = IDLE_TIMEOUT_DEF;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        abort;
    logic [1:0]  abort_id;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .abort_o     (abort),
        .abort_id_o  (abort_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_tx_valid;
        logic [7:0]  e_tx_data;
        logic [3:0]  e_ready;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},    32'(grant),     32'h0);
        check({tag, "_busy"},     32'(busy),      32'h0);
        check({tag, "_tx_valid"}, 32'(tx_valid),  32'h0);
        check({tag, "_tx_data"},  32'(tx_data),   32'h0);
        check({tag, "_ready"},    32'(req_ready), 32'h0);
        check({tag, "_abort"},    32'(abort),     32'h0);
    endtask

    initial begin
        int pos[4];
        int bad;
        int got;
        int p;
        int ph;

        // Single requester A1..A3, then r0/r1 competing with the pointer at 2.
        vecs[0] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[1] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};
        vecs[2] = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA2, 4'b0010};
        vecs[3] = '{4'b0010, 4'b0010, 32'h0000_A300, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA3, 4'b0010};
        vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[5] = '{4'b0011, 4'b0011, 32'h0000_C1B0, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[6] = '{4'b0011, 4'b0011, 32'h0000_C1B0, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hB0, 4'b0001};
        vecs[7] = '{4'b0010, 4'b0010, 32'h0000_C100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[8] = '{4'b0010, 4'b0010, 32'h0000_C100, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hC1, 4'b0010};
        vecs[9] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};

        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_abort_id", 32'(abort_id), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            req_data  = vecs[i].data;
            tx_ready  = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_grant", i),    32'(grant),     32'(vecs[i].e_grant));
            check($sformatf("v%0d_busy", i),     32'(busy),      32'(vecs[i].e_busy));
            check($sformatf("v%0d_tx_valid", i), 32'(tx_valid),  32'(vecs[i].e_tx_valid));
            check($sformatf("v%0d_tx_data", i),  32'(tx_data),   32'(vecs[i].e_tx_data));
            check($sformatf("v%0d_ready", i),    32'(req_ready), 32'(vecs[i].e_ready));
            tick();
        end

        // Contention: all four send two bytes {k+1, b} from reset.
        do_reset();
        for (int k = 0; k < N; k++) pos[k] = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int k = 0; k < N; k++) begin
                req_valid[k]       = (pos[k] < 2);
                req_last[k]        = (pos[k] == 1);
                req_data[8*k +: 8] = {4'(k + 1), 4'(pos[k])};
            end
            tx_ready = 1'b1;
            @(negedge clk);
            p  = cyc / 3;
            ph = cyc % 3;
            if (ph == 0) begin
                check($sformatf("cont%0d_grant", cyc), 32'(grant), 32'h0);
                check($sformatf("cont%0d_xfer", cyc), 32'(tx_valid & tx_ready), 32'h0);
            end else begin
                check($sformatf("cont%0d_grant", cyc), 32'(grant), 32'(4'b0001 << p));
                check($sformatf("cont%0d_xfer", cyc), 32'(tx_valid & tx_ready), 32'h1);
                check($sformatf("cont%0d_data", cyc), 32'(tx_data), 32'({4'(p + 1), 4'(ph - 1)}));
            end
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) pos[k]++;
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        check("cont_end_busy", 32'(busy), 32'h0);
        tick();

        // Backpressure: r2 byte 0x5A stalled 5000 cycles, must not time out.
        req_valid          = 4'b0100;
        req_last           = 4'b0000;
        req_data[23:16]    = 8'h59;
        tx_ready           = 1'b1;
        tick();
        @(negedge clk);
        check("bp_grant", 32'(grant), 32'h4);
        check("bp_first_data", 32'(tx_data), 32'h59);
        tick();
        req_data[23:16] = 8'h5A;
        req_last        = 4'b0100;
        tx_ready        = 1'b0;
        bad = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (tx_data !== 8'h5A || tx_valid !== 1'b1 || abort !== 1'b0 ||
                grant !== 4'b0100 || req_ready !== 4'b0000) bad++;
            tick();
        end
        check("bp_stall_bad_cycles", 32'(bad), 32'h0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'h4);
        check("bp_release_data", 32'(tx_data), 32'h5A);
        tick();
        check("bp_done_busy", 32'(busy), 32'h0);
        check("bp_done_abort", 32'(abort), 32'h0);

        // Watchdog: r3 sends 0x11 then goes silent while r0 waits.
        req_valid       = 4'b1000;
        req_last        = 4'b0000;
        req_data[31:24] = 8'h11;
        tick();
        @(negedge clk);
        check("wd_grant", 32'(grant), 32'h8);
        check("wd_data", 32'(tx_data), 32'h11);
        tick();
        req_valid      = 4'b0001;
        req_last       = 4'b0001;
        req_data[7:0]  = 8'h22;
        got = 0;
        bad = 0;
        for (int n = 1; n <= int'(IT) + 20; n++) begin
            tick();
            if (abort === 1'b1) begin
                got = n;
                break;
            end
            if (grant !== 4'b1000) bad++;
        end
        check("wd_abort_delay", 32'(got), IT);
        check("wd_hold_grant_bad", 32'(bad), 32'h0);
        check("wd_abort_id", 32'(abort_id), 32'h3);
        check("wd_abort_grant", 32'(grant), 32'h0);
        check("wd_abort_busy", 32'(busy), 32'h0);
        tick();
        check("wd_pulse_end", 32'(abort), 32'h0);
        check("wd_next_grant", 32'(grant), 32'h1);
        check("wd_next_data", 32'(tx_data), 32'h22);

        // Reset mid-packet: move pointer to 2 with an r1 packet, then reset during the next one.
        tick();
        req_valid       = 4'b0010;
        req_last        = 4'b0010;
        req_data[15:8]  = 8'h30;
        tick();
        @(negedge clk);
        check("rst_pre_data", 32'(tx_data), 32'h30);
        tick();
        req_last        = 4'b0000;
        req_data[15:8]  = 8'h31;
        tick();
        @(negedge clk);
        check("rst_mid_grant", 32'(grant), 32'h2);
        tick();
        req_data[15:8] = 8'h32;
        check("rst_mid_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk);
        rst_n           = 1'b1;
        req_valid       = 4'b0110;
        req_last        = 4'b0110;
        req_data[15:8]  = 8'h41;
        req_data[23:16] = 8'h42;
        tick();
        check("rst_after_grant", 32'(grant), 32'h2);
        check("rst_after_data", 32'(tx_data), 32'h41);
        tick();
        req_valid = 4'b0100;
        check("rst_gap_busy", 32'(busy), 32'h0);
        tick();
        check("rst_r2_grant", 32'(grant), 32'h4);
        check("rst_r2_data", 32'(tx_data), 32'h42);
        tick();

        // Single-byte packet from r3 with r0 and r3 re-requesting: pointer wraps to 0.
        req_valid       = 4'b1000;
        req_last        = 4'b1000;
        req_data[31:24] = 8'hFF;
        tick();
        req_valid     = 4'b1001;
        req_last      = 4'b1001;
        req_data[7:0] = 8'h01;
        @(negedge clk);
        check("wrap_grant", 32'(grant), 32'h8);
        check("wrap_data", 32'(tx_data), 32'hFF);
        check("wrap_ready", 32'(req_ready), 32'h8);
        tick();
        req_data[31:24] = 8'hEE;
        @(negedge clk);
        check("wrap_gap_busy", 32'(busy), 32'h0);
        tick();
        @(negedge clk);
        check("wrap_next_grant", 32'(grant), 32'h1);
        check("wrap_next_data", 32'(tx_data), 32'h01);
        tick();
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
